// File: rtl/mod_reduce_serial.sv
// mod_reduce_serial: residue of an unsigned operand modulo a constant, computed
// MSB-first by Horner's rule, CHUNK bits per clock, with valid/ready handshakes.
module mod_reduce_serial #(
  parameter int MODULUS  = 47,
  parameter int IN_WIDTH = 36,
  parameter int CHUNK    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(MODULUS)-1:0] out_residue,
  output logic                       busy
);

  localparam int NCHUNK = (IN_WIDTH + CHUNK - 1) / CHUNK;
  localparam int RW     = $clog2(MODULUS);
  localparam int SW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TW     = RW + CHUNK + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SW-1:0]    r_shift;
  logic [RW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    w_ext;
  logic [CHUNK-1:0] w_chunk;
  logic [RW-1:0]    w_acc_next;
  logic             w_accept;
  logic             w_release;
  logic             w_last;

  // acc*2^CHUNK + chunk is below MODULUS*2^CHUNK, so a restoring subtract of
  // MODULUS*2^i for i = CHUNK-1..0 leaves a value below MODULUS.
  function automatic logic [RW-1:0] horner_step(input logic [RW-1:0]    acc,
                                                input logic [CHUNK-1:0] chunk);
    logic [TW-1:0] v;
    logic [TW-1:0] sub;
    v = '0;
    v[RW+CHUNK-1:0] = {acc, chunk};
    for (int i = CHUNK - 1; i >= 0; i--) begin
      sub = TW'(MODULUS) << i;
      if (v >= sub) begin
        v = v - sub;
      end
    end
    return v[RW-1:0];
  endfunction

  always_comb begin
    w_ext = '0;
    w_ext[IN_WIDTH-1:0] = in_data;
  end

  assign w_chunk    = r_shift[SW-1 -: CHUNK];
  assign w_acc_next = horner_step(r_acc, w_chunk);
  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_release  = (r_state == S_DONE) && out_ready;
  assign w_last     = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_residue  = '0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !rst;
        if (w_accept) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        out_residue = r_acc;
        if (w_release) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath only moves on accept and in RUN, so acc stays frozen in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= w_ext;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_shift <= r_shift << CHUNK;
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: doc/mod_reduce_serial.md
MOD_REDUCE_SERIAL -- requirements
Module: mod_reduce_serial

Interface
REQ-001 SHALL have parameter MODULUS, default 47: constant modulus M, legal range 2..2^CHUNK.
REQ-002 SHALL have parameter IN_WIDTH, default 36: operand width in bits, legal range >= 1.
REQ-003 SHALL have parameter CHUNK, default 6: bits consumed per cycle, legal range 1..16.
REQ-004 SHALL derive localparams NCHUNK = ceil(IN_WIDTH/CHUNK) and RW = clog2(MODULUS).
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: operand offered.
REQ-008 SHALL have port in_ready, output, 1: block accepts an operand this cycle.
REQ-009 SHALL have port in_data, input, IN_WIDTH: unsigned operand.
REQ-010 SHALL have port out_valid, output, 1: residue available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the residue.
REQ-012 SHALL have port out_residue, output, RW: in_data mod MODULUS, range 0..MODULUS-1.
REQ-013 SHALL have port busy, output, 1: high in RUN and DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-015 IDLE: on in_valid & in_ready, capture in_data zero-extended to NCHUNK*CHUNK bits into a shift register, clear acc to 0, clear chunk counter, go to RUN.
REQ-016 RUN: each cycle, acc <= (acc * 2^CHUNK + top CHUNK bits of shift register) mod MODULUS (MSB-first Horner), shift register left by CHUNK, counter +1.
REQ-017 RUN: on the edge that processes chunk NCHUNK-1, go to DONE; out_valid rises NCHUNK cycles after the accepting edge.
REQ-018 Intermediate acc*2^CHUNK + chunk SHALL be computed at full width (RW+CHUNK+1 bits) before reduction; no truncation before mod.
REQ-019 The per-cycle reduction SHALL be single-cycle combinational; any structure (constant-modulus reduction or table) meeting REQ-016 is acceptable.
REQ-020 DONE: out_valid = 1, out_residue = acc; both held stable until out_valid & out_ready.
REQ-021 DONE: on out_ready, go to IDLE; no new operand accepted on that same edge (in_ready low in DONE).
REQ-022 Sustained throughput SHALL be one result per NCHUNK+2 cycles with out_ready tied high.
REQ-023 in_valid in RUN/DONE SHALL be ignored; in_data changes after acceptance SHALL not affect the result.
REQ-024 out_residue SHALL be 0 whenever out_valid = 0.
REQ-025 MODULUS = 2^k SHALL yield the low k bits of in_data (generic path, no special case required).

Reset
REQ-026 rst high at a rising edge SHALL force state IDLE, acc 0, counter 0, shift register 0.
REQ-027 Reset values: in_ready 1 after the reset edge (0 while rst asserted), out_valid 0, out_residue 0, busy 0.
REQ-028 rst in RUN or DONE SHALL abandon the operation; no out_valid for that operand afterwards.
REQ-029 rst SHALL take priority over every simultaneous handshake.

Verification (MODULUS=47, IN_WIDTH=36, CHUNK=6, NCHUNK=6 unless noted)
REQ-030 in_data=400, out_ready=1 -> out_residue=24, out_valid exactly 6 cycles after accepting edge, busy high 7 cycles.
REQ-031 in_data=0 -> 0; in_data=46 -> 46; in_data=47 -> 0; in_data=2^36-1 (68719476735) -> 13.
REQ-032 out_ready held low 5 cycles in DONE -> out_residue/out_valid stable; in_valid=1 with new data ignored; in_ready=0 throughout.
REQ-033 rst pulsed on 3rd RUN cycle of in_data=400 -> all outputs at reset values next cycle; next operand 1000 -> 13, correct latency.
REQ-034 Back-to-back in_valid=1, out_ready=1, 100 random operands -> each residue equals reference mod, one result per 8 cycles.
REQ-035 Re-run with MODULUS=13, IN_WIDTH=10, CHUNK=4 (NCHUNK=3, zero-pad 2 bits): in_data=1023 -> 9, 3-cycle latency.
